wb_sequencer: RTL and testbench

WB_SEQUENCER -- requirements
Module: wb_sequencer

---
 rtl/wb_pkg.sv | 27 ++
 rtl/wb_fifo_mem.sv | 33 +++
 rtl/wb_sequencer.sv | 158 +++++++++++++++
 tb/tb_wb_sequencer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared widths, default depth and the packed writeback packet carried by wb_sequencer.
package wb_pkg;

    localparam int unsigned NumLanes     = 4;
    localparam int unsigned RegDataW     = 64;
    localparam int unsigned RegAddrW     = 3;
    localparam int unsigned SegDataW     = 16;
    localparam int unsigned SegAddrW     = 3;
    localparam int unsigned OpSizeW      = 2;
    localparam int unsigned PtcIdW       = 7;
    localparam int unsigned DefaultDepth = 4;

    // Lane n of each multi-lane field occupies the n-th slice, lane 0 at the LSBs.
    typedef struct packed {
        logic [NumLanes*RegDataW-1:0] regdata;
        logic [NumLanes*RegAddrW-1:0] regaddr;
        logic [NumLanes-1:0]          regld;
        logic [OpSizeW-1:0]           opsize;
        logic [NumLanes*SegDataW-1:0] segdata;
        logic [NumLanes*SegAddrW-1:0] segaddr;
        logic [NumLanes-1:0]          segld;
        logic [PtcIdW-1:0]            ptcid;
    } wb_pkt_t;

    localparam int unsigned PktW = $bits(wb_pkt_t);

endpackage

// File: rtl/wb_fifo_mem.sv
// Packet storage for wb_sequencer: Depth entries, one write port, one asynchronous read port.
module wb_fifo_mem
    import wb_pkg::*;
#(
    parameter int unsigned Depth = DefaultDepth,
    localparam int unsigned AddrW = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  wb_pkt_t          wdata_i,
    input  logic [AddrW-1:0] raddr_i,
    output wb_pkt_t          rdata_o
);

    wb_pkt_t mem_q [Depth];
    wb_pkt_t mem_d [Depth];

    always_comb begin
        mem_d = mem_q;
        if (we_i) begin
            mem_d[waddr_i] = wdata_i;
        end
    end

    // Contents are never reset; occupancy is tracked by the sequencer.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/wb_sequencer.sv
// In-order writeback packet FIFO; the head is popped every cycle it is valid.
// Define WB_BYPASS_EN to forward a push into an empty FIFO straight to wb_* in the same cycle.
module wb_sequencer
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = DefaultDepth,
    localparam int unsigned PtrW = $clog2(DEPTH),
    localparam int unsigned CntW = $clog2(DEPTH) + 1
) (
    input  logic                         clk,
    input  logic                         clr,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NumLanes*RegDataW-1:0] in_regdata,
    input  logic [NumLanes*RegAddrW-1:0] in_regaddr,
    input  logic [NumLanes-1:0]          in_regld,
    input  logic [OpSizeW-1:0]           in_opsize,
    input  logic [NumLanes*SegDataW-1:0] in_segdata,
    input  logic [NumLanes*SegAddrW-1:0] in_segaddr,
    input  logic [NumLanes-1:0]          in_segld,
    input  logic [PtcIdW-1:0]            in_ptcid,
    input  logic                         flush,
    output logic [RegDataW-1:0]          wb_data1,
    output logic [RegDataW-1:0]          wb_data2,
    output logic [RegDataW-1:0]          wb_data3,
    output logic [RegDataW-1:0]          wb_data4,
    output logic [RegAddrW-1:0]          wb_addr1,
    output logic [RegAddrW-1:0]          wb_addr2,
    output logic [RegAddrW-1:0]          wb_addr3,
    output logic [RegAddrW-1:0]          wb_addr4,
    output logic [SegDataW-1:0]          wb_segdata1,
    output logic [SegDataW-1:0]          wb_segdata2,
    output logic [SegDataW-1:0]          wb_segdata3,
    output logic [SegDataW-1:0]          wb_segdata4,
    output logic [SegAddrW-1:0]          wb_segaddr1,
    output logic [SegAddrW-1:0]          wb_segaddr2,
    output logic [SegAddrW-1:0]          wb_segaddr3,
    output logic [SegAddrW-1:0]          wb_segaddr4,
    output logic [OpSizeW-1:0]           wb_opsize,
    output logic [NumLanes-1:0]          wb_regld,
    output logic [NumLanes-1:0]          wb_segld,
    output logic [PtcIdW-1:0]            wb_inst_ptcid,
    output logic [CntW-1:0]              count
);

    logic [PtrW-1:0] wptr_q, wptr_d;
    logic [PtrW-1:0] rptr_q, rptr_d;
    logic [CntW-1:0] count_q, count_d;

    wb_pkt_t in_pkt;
    wb_pkt_t head_pkt;
    wb_pkt_t out_pkt;

    logic push;
    logic pop;
    logic store;
    logic empty;

    assign in_pkt = '{
        regdata: in_regdata,
        regaddr: in_regaddr,
        regld:   in_regld,
        opsize:  in_opsize,
        segdata: in_segdata,
        segaddr: in_segaddr,
        segld:   in_segld,
        ptcid:   in_ptcid
    };

    assign empty    = (count_q == '0);
    assign in_ready = (count_q != CntW'(DEPTH));
    assign push     = in_valid && in_ready && !flush && clr;
    assign pop      = !empty;

`ifdef WB_BYPASS_EN
    // A packet forwarded from an empty FIFO has already been written back.
    assign store = push && !empty;
`else
    assign store = push;
`endif

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (store) begin
                wptr_d = wptr_q + PtrW'(1);
            end
            if (pop) begin
                rptr_d = rptr_q + PtrW'(1);
            end
            count_d = count_q + CntW'(store) - CntW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    wb_fifo_mem #(
        .Depth (DEPTH)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (store),
        .waddr_i (wptr_q),
        .wdata_i (in_pkt),
        .raddr_i (rptr_q),
        .rdata_o (head_pkt)
    );

    always_comb begin
        out_pkt = '0;
        if (!empty) begin
            out_pkt = head_pkt;
        end
`ifdef WB_BYPASS_EN
        else if (push) begin
            out_pkt = in_pkt;
        end
`endif
    end

    assign wb_data1      = out_pkt.regdata[0*RegDataW +: RegDataW];
    assign wb_data2      = out_pkt.regdata[1*RegDataW +: RegDataW];
    assign wb_data3      = out_pkt.regdata[2*RegDataW +: RegDataW];
    assign wb_data4      = out_pkt.regdata[3*RegDataW +: RegDataW];
    assign wb_addr1      = out_pkt.regaddr[0*RegAddrW +: RegAddrW];
    assign wb_addr2      = out_pkt.regaddr[1*RegAddrW +: RegAddrW];
    assign wb_addr3      = out_pkt.regaddr[2*RegAddrW +: RegAddrW];
    assign wb_addr4      = out_pkt.regaddr[3*RegAddrW +: RegAddrW];
    assign wb_segdata1   = out_pkt.segdata[0*SegDataW +: SegDataW];
    assign wb_segdata2   = out_pkt.segdata[1*SegDataW +: SegDataW];
    assign wb_segdata3   = out_pkt.segdata[2*SegDataW +: SegDataW];
    assign wb_segdata4   = out_pkt.segdata[3*SegDataW +: SegDataW];
    assign wb_segaddr1   = out_pkt.segaddr[0*SegAddrW +: SegAddrW];
    assign wb_segaddr2   = out_pkt.segaddr[1*SegAddrW +: SegAddrW];
    assign wb_segaddr3   = out_pkt.segaddr[2*SegAddrW +: SegAddrW];
    assign wb_segaddr4   = out_pkt.segaddr[3*SegAddrW +: SegAddrW];
    assign wb_opsize     = out_pkt.opsize;
    assign wb_regld      = out_pkt.regld;
    assign wb_segld      = out_pkt.segld;
    assign wb_inst_ptcid = out_pkt.ptcid;
    assign count         = count_q;

endmodule

// File: tb/tb_wb_sequencer.sv
// Randomised bench for wb_sequencer against a packet-queue reference model.
module tb_wb_sequencer;
    import wb_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CntW  = $clog2(DEPTH) + 1;

`ifdef WB_BYPASS_EN
    localparam bit Bypass = 1'b1;
`else
    localparam bit Bypass = 1'b0;
`endif

    logic clk = 1'b0;
    logic clr = 1'b0;
    logic in_valid = 1'b0;
    logic flush = 1'b0;
    wb_pkt_t in_pkt = '0;
    wb_pkt_t obs_pkt;
    logic in_ready;
    logic [CntW-1:0] count;

    logic [RegDataW-1:0] wb_data1, wb_data2, wb_data3, wb_data4;
    logic [RegAddrW-1:0] wb_addr1, wb_addr2, wb_addr3, wb_addr4;
    logic [SegDataW-1:0] wb_segdata1, wb_segdata2, wb_segdata3, wb_segdata4;
    logic [SegAddrW-1:0] wb_segaddr1, wb_segaddr2, wb_segaddr3, wb_segaddr4;
    logic [OpSizeW-1:0]  wb_opsize;
    logic [NumLanes-1:0] wb_regld, wb_segld;
    logic [PtcIdW-1:0]   wb_inst_ptcid;

    int n_checks = 0;
    int n_errors = 0;
    wb_pkt_t model_q[$];

    always #5 clk = ~clk;

    wb_sequencer #(
        .DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .clr           (clr),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_regdata    (in_pkt.regdata),
        .in_regaddr    (in_pkt.regaddr),
        .in_regld      (in_pkt.regld),
        .in_opsize     (in_pkt.opsize),
        .in_segdata    (in_pkt.segdata),
        .in_segaddr    (in_pkt.segaddr),
        .in_segld      (in_pkt.segld),
        .in_ptcid      (in_pkt.ptcid),
        .flush         (flush),
        .wb_data1      (wb_data1),
        .wb_data2      (wb_data2),
        .wb_data3      (wb_data3),
        .wb_data4      (wb_data4),
        .wb_addr1      (wb_addr1),
        .wb_addr2      (wb_addr2),
        .wb_addr3      (wb_addr3),
        .wb_addr4      (wb_addr4),
        .wb_segdata1   (wb_segdata1),
        .wb_segdata2   (wb_segdata2),
        .wb_segdata3   (wb_segdata3),
        .wb_segdata4   (wb_segdata4),
        .wb_segaddr1   (wb_segaddr1),
        .wb_segaddr2   (wb_segaddr2),
        .wb_segaddr3   (wb_segaddr3),
        .wb_segaddr4   (wb_segaddr4),
        .wb_opsize     (wb_opsize),
        .wb_regld      (wb_regld),
        .wb_segld      (wb_segld),
        .wb_inst_ptcid (wb_inst_ptcid),
        .count         (count)
    );

    assign obs_pkt.regdata = {wb_data4, wb_data3, wb_data2, wb_data1};
    assign obs_pkt.regaddr = {wb_addr4, wb_addr3, wb_addr2, wb_addr1};
    assign obs_pkt.regld   = wb_regld;
    assign obs_pkt.opsize  = wb_opsize;
    assign obs_pkt.segdata = {wb_segdata4, wb_segdata3, wb_segdata2, wb_segdata1};
    assign obs_pkt.segaddr = {wb_segaddr4, wb_segaddr3, wb_segaddr2, wb_segaddr1};
    assign obs_pkt.segld   = wb_segld;
    assign obs_pkt.ptcid   = wb_inst_ptcid;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic wb_pkt_t rand_pkt();
        wb_pkt_t p;
        p.regdata = {$urandom, $urandom, $urandom, $urandom,
                     $urandom, $urandom, $urandom, $urandom};
        p.regaddr = 12'($urandom);
        p.regld   = 4'($urandom);
        p.opsize  = 2'($urandom);
        p.segdata = {$urandom, $urandom};
        p.segaddr = 12'($urandom);
        p.segld   = 4'($urandom);
        p.ptcid   = 7'($urandom);
        return p;
    endfunction

    // One clock cycle: drive inputs, compare outputs with the model, then advance the model.
    task automatic step(input logic v, input wb_pkt_t p, input logic fl, input logic cl);
        bit      acc;
        bit      was_empty;
        wb_pkt_t exp_pkt;
        @(negedge clk);
        in_valid = v;
        in_pkt   = p;
        flush    = fl;
        clr      = cl;
        #1;
        was_empty = (model_q.size() == 0);
        acc       = v && (model_q.size() != DEPTH) && !fl && cl;
        exp_pkt   = '0;
        if (!was_empty) begin
            exp_pkt = model_q[0];
        end else if (Bypass && acc) begin
            exp_pkt = p;
        end
        check("wb_pkt", 512'(obs_pkt), 512'(exp_pkt));
        check("count", 512'(count), 512'(model_q.size()));
        check("in_ready", 512'(in_ready), 512'(model_q.size() != DEPTH));
        @(posedge clk);
        if (!cl || fl) begin
            model_q.delete();
        end else begin
            if (!was_empty) begin
                void'(model_q.pop_front());
            end
            if (acc && !(Bypass && was_empty)) begin
                model_q.push_back(p);
            end
        end
    endtask

    initial begin
        wb_pkt_t p;
        repeat (3) @(posedge clk);
        // Reset values straight out of reset.
        step(1'b0, '0, 1'b0, 1'b1);
        check("reset_count", 512'(count), 512'(0));
        check("reset_ready", 512'(in_ready), 512'(1));
        check("reset_regld", 512'(wb_regld), 512'(0));

        // Single directed push.
        p = '0;
        p.regld   = 4'b0001;
        p.regaddr = 12'd2;
        p.regdata = 256'h0000_0000_0000_DEAD;
        p.ptcid   = 7'd5;
        step(1'b1, p, 1'b0, 1'b1);
        repeat (3) step(1'b0, rand_pkt(), 1'b0, 1'b1);

        // Back-to-back pushes.
        repeat (5) step(1'b1, rand_pkt(), 1'b0, 1'b1);
        repeat (3) step(1'b0, rand_pkt(), 1'b0, 1'b1);

        // Flush together with a push.
        repeat (3) step(1'b1, rand_pkt(), 1'b0, 1'b1);
        step(1'b1, rand_pkt(), 1'b1, 1'b1);
        repeat (3) step(1'b0, rand_pkt(), 1'b0, 1'b1);

        // Reset in the middle of traffic, with a push in the reset cycle.
        repeat (3) step(1'b1, rand_pkt(), 1'b0, 1'b1);
        step(1'b1, rand_pkt(), 1'b0, 1'b0);
        repeat (3) step(1'b0, rand_pkt(), 1'b0, 1'b1);

        // Segment-only push into an empty FIFO.
        p = '0;
        p.segld   = 4'b1000;
        p.segaddr = 12'h200;
        p.segdata = 64'h0010_0000_0000_0000;
        step(1'b1, p, 1'b0, 1'b1);
        repeat (2) step(1'b0, rand_pkt(), 1'b0, 1'b1);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(99) < 70, rand_pkt(), $urandom_range(99) < 5,
                 !($urandom_range(99) < 3));
        end
        repeat (2) step(1'b0, rand_pkt(), 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
